// File: rtl/fifo_tx_pkg.sv
// Shared definitions for the FIFO-fed serial transmitter: FSM encoding,
// default geometry and counter sizing helper.
package fifo_tx_pkg;

   localparam int unsigned DEF_DATA_WIDTH   = 8;
   localparam int unsigned DEF_CLKS_PER_BIT = 4;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      POP   = 3'd1,
      LOAD  = 3'd2,
      START = 3'd3,
      DATA  = 3'd4,
      STOP  = 3'd5
   } state_t;

   // Counter width for a modulo-n counter, never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fifo_tx_serializer_bit_timer.sv
// Free-running modulo-CLKS_PER_BIT counter; bit_end marks the last clock
// of every serial bit period.
module bit_timer
   import fifo_tx_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic bit_end
);

   localparam int unsigned   CW   = cnt_width(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clear)
         cnt <= '0;
      else if (cnt == LAST)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

   assign bit_end = (cnt == LAST);

endmodule

// File: rtl/fifo_tx_serializer.sv
// Pops words from an upstream FIFO and sends each as an 8N1-style frame:
// start bit, DATA_WIDTH bits LSB first, stop bit, each CLKS_PER_BIT clocks.
module fifo_tx_serializer
   import fifo_tx_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  fifo_rd_en,
   output logic                  tx,
   output logic                  busy,
   output logic                  tx_done
);

   localparam int unsigned   BW       = cnt_width(DATA_WIDTH);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

   state_t                state, next_state;
   logic                  bit_end;
   logic                  timer_clear;
   logic [BW-1:0]         bit_cnt;
   logic [DATA_WIDTH-1:0] shreg, shreg_next;
   logic                  tx_next;

   // LOAD always precedes START, so clearing here aligns the timer to the start bit.
   assign timer_clear = (state == LOAD);

   bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (timer_clear),
      .bit_end (bit_end)
   );

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (!fifo_empty) next_state = POP;
         POP:     next_state = LOAD;
         LOAD:    next_state = START;
         START:   if (bit_end) next_state = DATA;
         DATA:    if (bit_end && bit_cnt == LAST_BIT) next_state = STOP;
         STOP:    if (bit_end) next_state = fifo_empty ? IDLE : POP;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      fifo_rd_en = (state == POP);
      busy       = (state != IDLE);
      tx_done    = (state == STOP) && bit_end;
   end

   // tx is computed from next_state so the registered line changes on the same edge as the state.
   always_comb begin
      shreg_next = shreg;
      if (state == LOAD)
         shreg_next = fifo_data;
      else if (state == DATA && bit_end)
         shreg_next = shreg >> 1;
      case (next_state)
         START:   tx_next = 1'b0;
         DATA:    tx_next = shreg_next[0];
         default: tx_next = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx      <= 1'b1;
         shreg   <= '0;
         bit_cnt <= '0;
      end else begin
         tx    <= tx_next;
         shreg <= shreg_next;
         if (state != DATA)
            bit_cnt <= '0;
         else if (bit_end)
            bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_fifo_tx_serializer.sv
// Directed bench: frame vectors from a table plus multi-cycle sequences for
// back-to-back, reset-abort, full-FIFO drain and single-clock bit timing.
module tb_fifo_tx_serializer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic       fifo_empty, fifo_rd_en, tx, busy, tx_done;
   logic [7:0] fifo_data;
   logic [7:0] mem [16];
   int unsigned wp = 0, rp = 0;

   logic       empty2, rd2, tx2, busy2, done2;
   logic [7:0] data2, word2;
   int unsigned wp2 = 0, rp2 = 0;

   int checks = 0, errors = 0;
   int rd_cnt = 0, done_cnt = 0, rd_empty_cnt = 0;

   typedef struct packed {
      logic [7:0] word;
      logic [9:0] frame;   // bit i = tx level during bit period i
   } vec_t;
   vec_t vecs [5];

   always #5 clk = ~clk;

   fifo_tx_serializer #(.DATA_WIDTH(8), .CLKS_PER_BIT(4)) dut (
      .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
      .fifo_rd_en(fifo_rd_en), .tx(tx), .busy(busy), .tx_done(tx_done)
   );

   fifo_tx_serializer #(.DATA_WIDTH(8), .CLKS_PER_BIT(1)) dut1 (
      .clk(clk), .rst(rst), .fifo_empty(empty2), .fifo_data(data2),
      .fifo_rd_en(rd2), .tx(tx2), .busy(busy2), .tx_done(done2)
   );

   // 16-deep FIFO with registered read
   assign fifo_empty = (wp == rp);
   always @(posedge clk)
      if (fifo_rd_en && wp != rp) begin
         fifo_data <= mem[rp % 16];
         rp <= rp + 1;
      end

   assign empty2 = (wp2 == rp2);
   always @(posedge clk)
      if (rd2 && wp2 != rp2) begin
         data2 <= word2;
         rp2 <= rp2 + 1;
      end

   always @(negedge clk) begin
      if (fifo_rd_en) rd_cnt++;
      if (tx_done) done_cnt++;
      if (fifo_rd_en && fifo_empty) rd_empty_cnt++;
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic push(input logic [7:0] w);
      mem[wp % 16] = w;
      wp = wp + 1;
   endtask

   task automatic wait_fall(input int which, output int n);
      n = 0;
      forever begin
         @(negedge clk);
         n++;
         if ((which ? tx2 : tx) == 1'b0 || n >= 200) break;
      end
   endtask

   // Called on the negedge where tx has just fallen; ends on the last stop sample.
   task automatic do_frame(input int which, input logic [9:0] exp, input int cpb, input string nm);
      logic [9:0] obs;
      logic       s, d;
      int         nbad, ndone, done_last;
      obs = '0; nbad = 0; ndone = 0; done_last = 0;
      for (int k = 0; k < cpb * 10; k++) begin
         if (k > 0) @(negedge clk);
         s = which ? tx2 : tx;
         d = which ? done2 : tx_done;
         if (k % cpb == 0) obs[k / cpb] = s;
         if (s !== exp[k / cpb]) nbad++;
         if (d) begin
            ndone++;
            if (k == cpb * 10 - 1) done_last = 1;
         end
      end
      chk({nm, " frame bits"}, int'(obs), int'(exp));
      chk({nm, " bad samples"}, nbad, 0);
      chk({nm, " tx_done count"}, ndone, 1);
      chk({nm, " tx_done on last stop cycle"}, done_last, 1);
   endtask

   initial begin
      int n, r0, d0, bad_tx, bad_busy, bad_rd;

      vecs[0] = '{word: 8'hA5, frame: 10'b1101001010};
      vecs[1] = '{word: 8'h00, frame: 10'b1000000000};
      vecs[2] = '{word: 8'hFF, frame: 10'b1111111110};
      vecs[3] = '{word: 8'h3C, frame: 10'b1001111000};
      vecs[4] = '{word: 8'h5A, frame: 10'b1010110100};

      // Reset state, then a long idle with the FIFO empty
      repeat (3) @(negedge clk);
      chk("reset tx", tx, 1);
      chk("reset busy", busy, 0);
      chk("reset rd_en", fifo_rd_en, 0);
      chk("reset tx_done", tx_done, 0);
      rst = 1'b0;
      bad_tx = 0; bad_busy = 0; bad_rd = 0;
      repeat (50) begin
         @(negedge clk);
         if (tx !== 1'b1) bad_tx++;
         if (busy !== 1'b0) bad_busy++;
         if (fifo_rd_en !== 1'b0) bad_rd++;
      end
      chk("idle tx low cycles", bad_tx, 0);
      chk("idle busy cycles", bad_busy, 0);
      chk("idle rd_en cycles", bad_rd, 0);

      // Single-word frames from the table
      for (int i = 0; i < 5; i++) begin
         r0 = rd_cnt; d0 = done_cnt;
         push(vecs[i].word);
         wait_fall(0, n);
         chk($sformatf("vec%0d latency", i), n, 3);
         do_frame(0, vecs[i].frame, 4, $sformatf("vec%0d", i));
         @(negedge clk);
         chk($sformatf("vec%0d busy after", i), busy, 0);
         chk($sformatf("vec%0d tx after", i), tx, 1);
         chk($sformatf("vec%0d rd pulses", i), rd_cnt - r0, 1);
         chk($sformatf("vec%0d done pulses", i), done_cnt - d0, 1);
      end

      // Back-to-back 00, FF
      r0 = rd_cnt;
      push(8'h00);
      push(8'hFF);
      wait_fall(0, n);
      chk("b2b latency", n, 3);
      do_frame(0, 10'b1000000000, 4, "b2b first");
      wait_fall(0, n);
      chk("b2b gap", n - 1, 2);
      do_frame(0, 10'b1111111110, 4, "b2b second");
      @(negedge clk);
      chk("b2b busy after", busy, 0);
      chk("b2b rd pulses", rd_cnt - r0, 2);

      // Reset during DATA bit 3 of a 3C frame
      r0 = rd_cnt;
      push(8'h3C);
      wait_fall(0, n);
      chk("abort latency", n, 3);
      repeat (17) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort tx", tx, 1);
      chk("abort busy", busy, 0);
      d0 = done_cnt;
      bad_tx = 0;
      repeat (60) begin
         @(negedge clk);
         if (tx !== 1'b1) bad_tx++;
      end
      chk("abort tx low after", bad_tx, 0);
      chk("abort done pulses", done_cnt - d0, 0);
      chk("abort rd pulses", rd_cnt - r0, 1);
      chk("abort fifo empty", fifo_empty, 1);

      // Full FIFO drain, 16 frames in order
      r0 = rd_cnt;
      for (int i = 0; i < 16; i++) push(8'(i));
      for (int i = 0; i < 16; i++) begin
         logic [7:0] w;
         w = 8'(i);
         wait_fall(0, n);
         chk($sformatf("full%0d lead-in", i), n, 3);
         do_frame(0, {1'b1, w, 1'b0}, 4, $sformatf("full%0d", i));
      end
      @(negedge clk);
      chk("full busy after", busy, 0);
      chk("full rd pulses", rd_cnt - r0, 16);
      chk("full fifo empty", fifo_empty, 1);
      chk("rd_en while empty", rd_empty_cnt, 0);

      // CLKS_PER_BIT=1 instance, word 81
      word2 = 8'h81;
      wp2 = 1;
      wait_fall(1, n);
      chk("cpb1 latency", n, 3);
      do_frame(1, 10'b1100000010, 1, "cpb1");
      @(negedge clk);
      chk("cpb1 busy after", busy2, 0);
      chk("cpb1 tx after", tx2, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
